// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and constants for the half-word SRAM controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned DEF_BASE_ADDR = 1024;

    localparam logic LO_HALF = 1'b0;
    localparam logic HI_HALF = 1'b1;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Pipeline request bundle and external 16-bit SRAM bus bundle.
interface mem_req_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output mem_r_en, mem_w_en, address, wdata, input rdata, ready);
    modport slave  (input mem_r_en, mem_w_en, address, wdata, output rdata, ready);
endinterface

interface sram_bus_if #(parameter int ADDR_W = 18);
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_out;
    logic [15:0]       sram_dq_in;
    logic              sram_dq_oe;
    logic              sram_we_n;

    modport master (output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, input sram_dq_in);
    modport slave  (input sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, output sram_dq_in);
endinterface

// File: rtl/sram_mem_ctrl.sv
// Splits a 32-bit load/store into two 16-bit SRAM accesses with programmable wait states.
//   state | meaning
//   IDLE  | no transfer; request and address latched on entry to LO
//   LO    | low half-word on bus for WAIT_CYCLES cycles
//   HI    | high half-word on bus for WAIT_CYCLES cycles
//   DONE  | bus idle, ready high for one cycle
module sram_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int ADDR_W      = 18
) (
    input  logic      clk,
    input  logic      rst,
    mem_req_if.slave  req,
    sram_bus_if.master sram
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-2:0]   word_q, word_d;
    logic [15:0]         wdata_hi_q, wdata_hi_d;
    logic                wr_q, wr_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         dq_q, dq_d;
    logic                oe_q, oe_d;
    logic                we_n_q, we_n_d;

    logic                req_v;
    logic                last_cnt;
    logic                ready_c;
    logic [31:0]         offs;
    logic [ADDR_W-2:0]   word_in;

    // Addresses below the data base fold onto word 0; the word index wraps.
    always_comb begin
        offs    = req.address - 32'(BASE_ADDR);
        word_in = '0;
        if (req.address >= 32'(BASE_ADDR)) begin
            word_in = (ADDR_W-1)'(offs >> 2);
        end
    end

    assign req_v    = req.mem_r_en | req.mem_w_en;
    assign last_cnt = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        wdata_hi_d = wdata_hi_q;
        wr_d       = wr_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        dq_d       = dq_q;
        oe_d       = oe_q;
        we_n_d     = we_n_q;
        ready_c    = 1'b0;

        case (state_q)
            IDLE: begin
                ready_c = ~req_v;
                if (req_v) begin
                    state_d    = LO;
                    cnt_d      = '0;
                    word_d     = word_in;
                    wdata_hi_d = req.wdata[31:16];
                    wr_d       = req.mem_w_en;
                    addr_d     = {word_in, LO_HALF};
                    dq_d       = req.wdata[15:0];
                    oe_d       = req.mem_w_en;
                    we_n_d     = ~req.mem_w_en;
                end
            end
            LO: begin
                if (last_cnt) begin
                    cnt_d   = '0;
                    state_d = HI;
                    if (!wr_q) begin
                        rdata_d[15:0] = sram.sram_dq_in;
                    end
                    addr_d = {word_q, HI_HALF};
                    dq_d   = wdata_hi_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HI: begin
                if (last_cnt) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!wr_q) begin
                        rdata_d[31:16] = sram.sram_dq_in;
                    end
                    oe_d   = 1'b0;
                    we_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                ready_c = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            wdata_hi_q <= '0;
            wr_q       <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            dq_q       <= '0;
            oe_q       <= 1'b0;
            we_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            wdata_hi_q <= wdata_hi_d;
            wr_q       <= wr_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            dq_q       <= dq_d;
            oe_q       <= oe_d;
            we_n_q     <= we_n_d;
        end
    end

    assign req.ready        = ready_c;
    assign req.rdata        = rdata_q;
    assign sram.sram_addr   = addr_q;
    assign sram.sram_dq_out = dq_q;
    assign sram.sram_dq_oe  = oe_q;
    assign sram.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: one instance with 1 wait state, one with 3.
module tb_sram_mem_ctrl;

    typedef struct {
        int          lat;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        logic [17:0] a;
        logic [15:0] dq;
        logic        oe;
        logic        we_n;
    } tr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        r_en, w_en;
    logic [31:0] addr, wdata;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 0;
    exp_t exp_q[$];
    tr_t  trace_q[$];

    always #5 clk = ~clk;

    mem_req_if q1();
    mem_req_if q3();
    sram_bus_if #(.ADDR_W(18)) b1();
    sram_bus_if #(.ADDR_W(18)) b3();

    assign q1.mem_r_en = r_en & ~sel;
    assign q1.mem_w_en = w_en & ~sel;
    assign q1.address  = addr;
    assign q1.wdata    = wdata;
    assign q3.mem_r_en = r_en & sel;
    assign q3.mem_w_en = w_en & sel;
    assign q3.address  = addr;
    assign q3.wdata    = wdata;

    sram_mem_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(1024), .ADDR_W(18)) dut1 (
        .clk(clk), .rst(rst), .req(q1), .sram(b1));
    sram_mem_ctrl #(.WAIT_CYCLES(3), .BASE_ADDR(1024), .ADDR_W(18)) dut3 (
        .clk(clk), .rst(rst), .req(q3), .sram(b3));

    // Behavioural 16-bit SRAMs: async read, write on rising edge while we_n is low.
    logic [15:0] mem1 [0:262143];
    logic [15:0] mem3 [0:262143];
    always @(posedge clk) if (!b1.sram_we_n) mem1[b1.sram_addr] <= b1.sram_dq_out;
    always @(posedge clk) if (!b3.sram_we_n) mem3[b3.sram_addr] <= b3.sram_dq_out;
    assign b1.sram_dq_in = mem1[b1.sram_addr];
    assign b3.sram_dq_in = mem3[b3.sram_addr];

    logic        m_req, m_ready, m_oe, m_we_n;
    logic [31:0] m_rdata;
    logic [17:0] m_addr;
    logic [15:0] m_dq;
    assign m_req   = r_en | w_en;
    assign m_ready = sel ? q3.ready : q1.ready;
    assign m_rdata = sel ? q3.rdata : q1.rdata;
    assign m_addr  = sel ? b3.sram_addr : b1.sram_addr;
    assign m_dq    = sel ? b3.sram_dq_out : b1.sram_dq_out;
    assign m_oe    = sel ? b3.sram_dq_oe : b1.sram_dq_oe;
    assign m_we_n  = sel ? b3.sram_we_n : b1.sram_we_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: records the bus each cycle of a request and scores each completion.
    always @(negedge clk) begin
        if (rst) begin
            lat = 0;
        end else if (m_req) begin
            trace_q.push_back('{m_addr, m_dq, m_oe, m_we_n});
            if (!m_ready) begin
                lat++;
            end else begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("latency", 32'(lat), 32'(e.lat));
                    check("rdata", m_rdata, e.rd);
                end
                lat = 0;
            end
        end
    end

    task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int exp_lat,
                        input logic [31:0] exp_rd, input bit scramble);
        bit done;
        exp_q.push_back('{exp_lat, exp_rd});
        trace_q.delete();
        r_en  = rd;
        w_en  = wr;
        addr  = a;
        wdata = d;
        done  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_ready) begin
                done = 1'b1;
                break;
            end
            if (scramble && i == 1) begin
                addr  = 32'hFFFF_FFF0;
                wdata = 32'h0000_0000;
            end
        end
        if (!done) begin
            check("timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        r_en = 1'b0;
        w_en = 1'b0;
    endtask

    task automatic check_trace(input string name, input int idx, input logic [17:0] a);
        if (trace_q.size() > idx) check(name, 32'(trace_q[idx].a), 32'(a));
        else check({name, "_missing"}, 32'(trace_q.size()), 32'(idx + 1));
    endtask

    initial begin
        rst   = 1'b1;
        sel   = 1'b0;
        r_en  = 1'b0;
        w_en  = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(m_ready), 32'd1);
        check("rst_we_n", 32'(m_we_n), 32'd1);
        check("rst_oe", 32'(m_oe), 32'd0);
        check("rst_rdata", m_rdata, 32'h0);
        check("rst_addr", 32'(m_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write with inputs scrambled once the transfer is under way.
        xfer(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 3, 32'h0, 1'b1);
        check_trace("wr_lo_addr", 1, 18'd2);
        check_trace("wr_hi_addr", 2, 18'd3);
        if (trace_q.size() > 2) begin
            check("wr_lo_dq", 32'(trace_q[1].dq), 32'h0000BEEF);
            check("wr_lo_we_n", 32'(trace_q[1].we_n), 32'd0);
            check("wr_lo_oe", 32'(trace_q[1].oe), 32'd1);
            check("wr_hi_dq", 32'(trace_q[2].dq), 32'h0000DEAD);
            check("wr_hi_we_n", 32'(trace_q[2].we_n), 32'd0);
        end
        check("mem1_2", 32'(mem1[2]), 32'h0000BEEF);
        check("mem1_3", 32'(mem1[3]), 32'h0000DEAD);

        xfer(1'b1, 1'b0, 32'd1028, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        begin
            logic any_low;
            any_low = 1'b0;
            foreach (trace_q[i]) if (!trace_q[i].we_n || trace_q[i].oe) any_low = 1'b1;
            check("rd_bus_quiet", 32'(any_low), 32'd0);
        end

        // Back-to-back below-base write then read; both fold onto half-words 0/1.
        xfer(1'b0, 1'b1, 32'd512, 32'h1234A5A5, 3, 32'hDEADBEEF, 1'b0);
        check("mem1_0", 32'(mem1[0]), 32'h0000A5A5);
        xfer(1'b1, 1'b0, 32'd512, 32'h0, 3, 32'h1234A5A5, 1'b0);
        check_trace("below_lo", 1, 18'd0);
        check_trace("below_hi", 2, 18'd1);

        xfer(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 3, 32'h1234A5A5, 1'b0);
        check("both_mem4", 32'(mem1[4]), 32'h0000F00D);
        check("both_mem5", 32'(mem1[5]), 32'h0000CAFE);

        // Three wait states per half-word.
        @(posedge clk);
        #1;
        sel = 1'b1;
        xfer(1'b0, 1'b1, 32'd1036, 32'hAAAA5555, 7, 32'h0, 1'b0);
        xfer(1'b1, 1'b0, 32'd1036, 32'h0, 7, 32'hAAAA5555, 1'b0);
        for (int i = 1; i <= 3; i++) check_trace("w3_lo_addr", i, 18'd6);
        for (int i = 4; i <= 6; i++) check_trace("w3_hi_addr", i, 18'd7);

        // Reset in the high phase of a write leaves only the low half written.
        @(posedge clk);
        #1;
        sel = 1'b0;
        xfer(1'b0, 1'b1, 32'd1040, 32'h0BAD0BAD, 3, 32'h1234A5A5, 1'b0);
        w_en  = 1'b1;
        addr  = 32'd1040;
        wdata = 32'h12345678;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_hi_we_n", 32'(m_we_n), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_we_n", 32'(m_we_n), 32'd1);
        check("mid_rst_oe", 32'(m_oe), 32'd0);
        check("mid_rst_rdata", m_rdata, 32'h0);
        w_en = 1'b0;
        #1;
        check("mid_rst_ready", 32'(m_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_mem8", 32'(mem1[8]), 32'h00005678);
        check("mid_mem9", 32'(mem1[9]), 32'h00000BAD);
        xfer(1'b1, 1'b0, 32'd1040, 32'h0, 3, 32'h0BAD5678, 1'b0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
